// File: rtl/ac97_pkg.sv
// Shared constants, the per-frame shadow record and the frame bit lookup for the AC'97
// output frame serializer.
package ac97_pkg;

    localparam int unsigned FRAME_BITS  = 256;
    localparam int unsigned TAG_BITS    = 16;
    localparam int unsigned SLOT_BITS   = 20;
    localparam int unsigned SLOT1_START = 16;
    localparam int unsigned SLOT2_START = 36;
    localparam int unsigned SLOT3_START = 56;
    localparam int unsigned SLOT4_START = 76;
    // Everything after slot 4 is zero, so only this many leading bits carry data.
    localparam int unsigned DATA_BITS   = SLOT4_START + SLOT_BITS;

    localparam int unsigned TAG_FRAME_VALID = 15;
    localparam int unsigned TAG_SLOT1_VALID = 14;
    localparam int unsigned TAG_SLOT2_VALID = 13;
    localparam int unsigned TAG_SLOT3_VALID = 12;
    localparam int unsigned TAG_SLOT4_VALID = 11;

    // Everything one frame transmits, frozen at the frame boundary.
    typedef struct packed {
        logic                 ready;
        logic                 cmd_vld;
        logic                 cmd_wr;
        logic [6:0]           cmd_addr;
        logic [15:0]          cmd_data;
        logic [SLOT_BITS-1:0] pcm;
    } frame_shadow_t;

    // Bit transmitted at frame position idx (0 = first bit after SYNC rises).
    function automatic logic frame_bit(logic [7:0] idx, frame_shadow_t s);
        logic [TAG_BITS-1:0]  tag;
        logic [SLOT_BITS-1:0] slot1;
        logic [SLOT_BITS-1:0] slot2;
        logic [DATA_BITS-1:0] frame;
        tag                  = '0;
        tag[TAG_FRAME_VALID] = s.ready;
        tag[TAG_SLOT1_VALID] = s.cmd_vld;
        tag[TAG_SLOT2_VALID] = s.cmd_vld & s.cmd_wr;
        tag[TAG_SLOT3_VALID] = s.ready;
        tag[TAG_SLOT4_VALID] = s.ready;
        slot1 = s.cmd_vld ? {~s.cmd_wr, s.cmd_addr, 12'h000} : '0;
        slot2 = (s.cmd_vld && s.cmd_wr) ? {s.cmd_data, 4'h0} : '0;
        frame = '0;
        frame[DATA_BITS-1 -: TAG_BITS]               = tag;
        frame[DATA_BITS-1-SLOT1_START -: SLOT_BITS]  = slot1;
        frame[DATA_BITS-1-SLOT2_START -: SLOT_BITS]  = slot2;
        frame[DATA_BITS-1-SLOT3_START -: SLOT_BITS]  = s.pcm;
        frame[DATA_BITS-1-SLOT4_START -: SLOT_BITS]  = s.pcm;
        // Shifting past the data region leaves zeros, which covers bits 96..255.
        frame = frame << idx;
        return s.ready & frame[DATA_BITS-1];
    endfunction

endpackage

// File: rtl/ac97_cmd_buffer.sv
// One-entry codec-register command buffer. Filled by a valid/ready transfer, emptied only
// by the consume strobe at a frame boundary. Built only when AC97_TX_CMD_EN is defined.
module ac97_cmd_buffer
    import ac97_pkg::*;
(
    input  logic        BIT_CLK,
    input  logic        RST_N,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [6:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    input  logic        consume,
    output logic        full,
    output logic        buf_write,
    output logic [6:0]  buf_addr,
    output logic [15:0] buf_data
);

    logic        full_q, full_d;
    logic        write_q, write_d;
    logic [6:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;

    // Ready is held low while reset is asserted even though the buffer is empty.
    assign cmd_ready = RST_N & ~full_q;
    assign full      = full_q;
    assign buf_write = write_q;
    assign buf_addr  = addr_q;
    assign buf_data  = data_q;

    // Next state: a transfer fills the buffer, a consume strobe empties it.
    always_comb begin
        full_d  = full_q;
        write_d = write_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (cmd_valid && cmd_ready) begin
            full_d  = 1'b1;
            write_d = cmd_write;
            addr_d  = cmd_addr;
            data_d  = cmd_data;
        end else if (consume) begin
            full_d  = 1'b0;
        end
    end

    // Buffer state register with synchronous reset.
    always_ff @(posedge BIT_CLK) begin
        if (!RST_N) begin
            full_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            full_q  <= full_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/ac97_frame_tx.sv
// AC'97 output frame serializer: one 256-bit frame per sample period carrying the PCM sample
// on slots 3/4 and, when AC97_TX_CMD_EN is defined, codec-register commands on slots 1/2.
module ac97_frame_tx
    import ac97_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 18
) (
    input  logic                BIT_CLK,
    input  logic                RST_N,
    input  logic [SAMPLE_W-1:0] PCM_LR,
    input  logic                codec_ready,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [6:0]          cmd_addr,
    input  logic [15:0]         cmd_data,
    output logic                SYNC,
    output logic                SDATA_OUT,
    output logic                frame_sig
);

    localparam int unsigned CNT_W = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    frame_shadow_t        shadow_q, shadow_d;
    logic                 sync_q, sync_d;
    logic                 sdata_q, sdata_d;
    logic                 fsig_q, fsig_d;
    logic                 boundary;
    logic [SLOT_BITS-1:0] pcm_slot;
    logic                 consume;
    logic                 buf_write;
    logic [6:0]           buf_addr;
    logic [15:0]          buf_data;

    assign boundary = (cnt_q == CNT_LAST);
    assign pcm_slot = SLOT_BITS'(PCM_LR) << (SLOT_BITS - SAMPLE_W);

`ifdef AC97_TX_CMD_EN
    logic buf_full;

    // A buffered command is only taken by a frame the codec will actually accept.
    assign consume = boundary & buf_full & codec_ready;

    ac97_cmd_buffer u_cmd_buffer (
        .BIT_CLK   (BIT_CLK),
        .RST_N     (RST_N),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .consume   (consume),
        .full      (buf_full),
        .buf_write (buf_write),
        .buf_addr  (buf_addr),
        .buf_data  (buf_data)
    );
`else
    logic unused_cmd;

    assign cmd_ready  = 1'b0;
    assign consume    = 1'b0;
    assign buf_write  = 1'b0;
    assign buf_addr   = '0;
    assign buf_data   = '0;
    assign unused_cmd = ^{cmd_valid, cmd_write, cmd_addr, cmd_data};
`endif

    // Next count, boundary shadow load, and pin values for the bit the next count selects.
    always_comb begin
        cnt_d    = cnt_q + CNT_W'(1);
        shadow_d = shadow_q;
        if (boundary) begin
            shadow_d.ready    = codec_ready;
            shadow_d.pcm      = pcm_slot;
            shadow_d.cmd_vld  = consume;
            shadow_d.cmd_wr   = consume & buf_write;
            shadow_d.cmd_addr = consume ? buf_addr : '0;
            shadow_d.cmd_data = consume ? buf_data : '0;
        end
        // Pins are registered, so they are derived from the post-edge count and shadow.
        sync_d  = (cnt_d < CNT_W'(TAG_BITS));
        sdata_d = frame_bit(cnt_d, shadow_d);
        fsig_d  = (cnt_d == CNT_LAST);
    end

    // Counter, shadow and output registers; reset aborts any frame in progress.
    always_ff @(posedge BIT_CLK) begin
        if (!RST_N) begin
            cnt_q    <= CNT_LAST;
            shadow_q <= '0;
            sync_q   <= 1'b0;
            sdata_q  <= 1'b0;
            fsig_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            sync_q   <= sync_d;
            sdata_q  <= sdata_d;
            fsig_q   <= fsig_d;
        end
    end

    assign SYNC      = sync_q;
    assign SDATA_OUT = sdata_q;
    assign frame_sig = fsig_q;

endmodule

// File: tb/tb_ac97_frame_tx.sv
// Bench for ac97_frame_tx. The reference model holds the expected frame as a 256-bit image
// assembled from the slot layout and replays it against the pins. Honours AC97_TX_CMD_EN.
module tb_ac97_frame_tx;

`ifdef AC97_TX_CMD_EN
    localparam bit CMD_EN = 1'b1;
`else
    localparam bit CMD_EN = 1'b0;
`endif

    logic        BIT_CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [17:0] PCM_LR = '0;
    logic        codec_ready = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [6:0]  cmd_addr = '0;
    logic [15:0] cmd_data = '0;
    logic        SYNC;
    logic        SDATA_OUT;
    logic        frame_sig;

    int n_cmp = 0;
    int n_fail = 0;

    ac97_frame_tx #(.SAMPLE_W(18)) dut (
        .BIT_CLK     (BIT_CLK),
        .RST_N       (RST_N),
        .PCM_LR      (PCM_LR),
        .codec_ready (codec_ready),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .SYNC        (SYNC),
        .SDATA_OUT   (SDATA_OUT),
        .frame_sig   (frame_sig)
    );

    always #5 BIT_CLK = ~BIT_CLK;

    // ---------------- reference model ----------------
    bit         m_rst = 1'b1;
    bit [7:0]   m_cnt = 8'd255;
    bit         m_full = 1'b0;
    bit         m_wr = 1'b0;
    bit [6:0]   m_addr = '0;
    bit [15:0]  m_data = '0;
    bit [0:255] m_frame = '0;
    logic [0:255] cap = '0;
    logic [0:255] last_frame = '0;

    // Whole frame image, index = bit period.
    function automatic bit [0:255] frame_of(bit ready, bit has_cmd, bit wr, bit [6:0] addr,
                                            bit [15:0] data, bit [19:0] pcm);
        bit [15:0] tag;
        bit [19:0] s1;
        bit [19:0] s2;
        if (!ready) return '0;
        tag = 16'h9800;
        if (has_cmd) tag = tag | 16'h4000;
        if (has_cmd && wr) tag = tag | 16'h2000;
        s1 = has_cmd ? {~wr, addr, 12'h000} : 20'h0;
        s2 = (has_cmd && wr) ? {data, 4'h0} : 20'h0;
        return {tag, s1, s2, pcm, pcm, 160'b0};
    endfunction

    always @(posedge BIT_CLK) begin
        if (!RST_N) begin
            m_rst   <= 1'b1;
            m_cnt   <= 8'd255;
            m_full  <= 1'b0;
            m_frame <= '0;
        end else begin
            m_rst <= 1'b0;
            m_cnt <= m_cnt + 8'd1;
            if (m_cnt == 8'd255)
                m_frame <= frame_of(codec_ready, m_full && codec_ready, m_wr, m_addr, m_data,
                                    {PCM_LR, 2'b00});
            if (CMD_EN && cmd_valid && !m_full) begin
                m_full <= 1'b1;
                m_wr   <= cmd_write;
                m_addr <= cmd_addr;
                m_data <= cmd_data;
            end else if (m_cnt == 8'd255 && m_full && codec_ready) begin
                m_full <= 1'b0;
            end
        end
    end

    // Records the serial stream; last_frame holds the most recently completed frame.
    always @(negedge BIT_CLK) begin
        if (!m_rst) begin
            cap[m_cnt] <= SDATA_OUT;
            if (m_cnt == 8'd255) last_frame <= {cap[0:254], SDATA_OUT};
        end
    end

    function automatic logic [3:0] exp_out();
        logic s, d, f, r;
        s = !m_rst && (m_cnt < 8'd16);
        d = !m_rst && m_frame[m_cnt];
        f = !m_rst && (m_cnt == 8'd255);
        r = CMD_EN && RST_N && !m_full;
        return {s, d, f, r};
    endfunction

    task automatic wait_cnt(input bit [7:0] k);
        int n = 0;
        do begin
            @(negedge BIT_CLK);
            n++;
        end while (m_cnt != k && n < 600);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST_N = 1'b0;
        PCM_LR = 18'($urandom);
        repeat (3) @(negedge BIT_CLK);
        n_cmp++;
        if ({SYNC, SDATA_OUT, frame_sig, cmd_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_pins: got %b want 0000", {SYNC, SDATA_OUT, frame_sig, cmd_ready});
        end
        RST_N = 1'b1;
        @(negedge BIT_CLK);
        n_cmp++;
        if ({SYNC, SDATA_OUT, frame_sig, cmd_ready} !== {3'b110, CMD_EN}) begin
            n_fail++;
            $display("FAIL first_edge: got %b want %b", {SYNC, SDATA_OUT, frame_sig, cmd_ready},
                     {3'b110, CMD_EN});
        end
    endtask

    task automatic test_pcm_stream();
        int syncs = 0;
        int pulses = 0;
        codec_ready = 1'b1;
        cmd_valid = 1'b0;
        wait_cnt(8'd255);
        PCM_LR = 18'h2AAAA;
        for (int k = 0; k < 3 * 256; k++) begin
            @(negedge BIT_CLK);
            n_cmp++;
            if ({SYNC, SDATA_OUT, frame_sig, cmd_ready} !== exp_out()) begin
                n_fail++;
                $display("FAIL stream_pins cnt=%0d: got %b want %b", m_cnt,
                         {SYNC, SDATA_OUT, frame_sig, cmd_ready}, exp_out());
            end
            syncs += int'(SYNC);
            pulses += int'(frame_sig);
        end
        @(negedge BIT_CLK);
        n_cmp++;
        if (syncs != 48 || pulses != 3) begin
            n_fail++;
            $display("FAIL stream_counts: got sync=%0d fsig=%0d want 48 3", syncs, pulses);
        end
        n_cmp++;
        if (last_frame[0:15] !== 16'h9800) begin
            n_fail++;
            $display("FAIL stream_tag: got %h want 9800", last_frame[0:15]);
        end
        n_cmp++;
        if (last_frame[56:75] !== 20'hAAAA8 || last_frame[76:95] !== 20'hAAAA8) begin
            n_fail++;
            $display("FAIL stream_slots34: got %h %h want AAAA8", last_frame[56:75],
                     last_frame[76:95]);
        end
    endtask

    task automatic test_capture_hold();
        wait_cnt(8'd255);
        PCM_LR = 18'h00001;
        wait_cnt(8'd100);
        PCM_LR = 18'h3FFFF;
        wait_cnt(8'd255);
        @(negedge BIT_CLK);
        n_cmp++;
        if (last_frame[56:75] !== 20'h00004 || last_frame[76:95] !== 20'h00004) begin
            n_fail++;
            $display("FAIL hold_current: got %h %h want 00004", last_frame[56:75],
                     last_frame[76:95]);
        end
        wait_cnt(8'd255);
        @(negedge BIT_CLK);
        n_cmp++;
        if (last_frame[56:75] !== 20'hFFFFC) begin
            n_fail++;
            $display("FAIL hold_next: got %h want FFFFC", last_frame[56:75]);
        end
    endtask

    task automatic test_write_cmd();
        wait_cnt(8'd39);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr = 7'h02;
        cmd_data = 16'h0808;
        @(negedge BIT_CLK);
        cmd_valid = 1'b0;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_ready_after_accept: got %b want 0", cmd_ready);
        end
        wait_cnt(8'd255);
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_ready_held: got %b want 0", cmd_ready);
        end
        @(negedge BIT_CLK);
        n_cmp++;
        if (cmd_ready !== CMD_EN) begin
            n_fail++;
            $display("FAIL wr_ready_return: got %b want %b", cmd_ready, CMD_EN);
        end
        wait_cnt(8'd255);
        @(negedge BIT_CLK);
        n_cmp++;
        if (last_frame[0:15] !== (CMD_EN ? 16'hF800 : 16'h9800) ||
            last_frame[16:35] !== (CMD_EN ? 20'h02000 : 20'h0) ||
            last_frame[36:55] !== (CMD_EN ? 20'h08080 : 20'h0)) begin
            n_fail++;
            $display("FAIL wr_frame: got tag %h s1 %h s2 %h want cmd_en=%b write 02/0808",
                     last_frame[0:15], last_frame[16:35], last_frame[36:55], CMD_EN);
        end
        wait_cnt(8'd255);
        @(negedge BIT_CLK);
        n_cmp++;
        if (last_frame[0:15] !== 16'h9800) begin
            n_fail++;
            $display("FAIL wr_after_tag: got %h want 9800", last_frame[0:15]);
        end
    endtask

    task automatic test_read_boundary();
        wait_cnt(8'd255);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr = 7'h26;
        cmd_data = 16'($urandom);
        @(negedge BIT_CLK);
        cmd_valid = 1'b0;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_ready_after_accept: got %b want 0", cmd_ready);
        end
        wait_cnt(8'd255);
        @(negedge BIT_CLK);
        n_cmp++;
        if (last_frame[0:15] !== 16'h9800 || last_frame[16:35] !== 20'h0) begin
            n_fail++;
            $display("FAIL rd_not_early: got tag %h s1 %h want 9800 00000", last_frame[0:15],
                     last_frame[16:35]);
        end
        n_cmp++;
        if (cmd_ready !== CMD_EN) begin
            n_fail++;
            $display("FAIL rd_ready_return: got %b want %b", cmd_ready, CMD_EN);
        end
        wait_cnt(8'd255);
        @(negedge BIT_CLK);
        n_cmp++;
        if (last_frame[0:15] !== (CMD_EN ? 16'hD800 : 16'h9800) ||
            last_frame[16:35] !== (CMD_EN ? 20'hA6000 : 20'h0) ||
            last_frame[36:55] !== 20'h0) begin
            n_fail++;
            $display("FAIL rd_frame: got tag %h s1 %h s2 %h want cmd_en=%b read 26",
                     last_frame[0:15], last_frame[16:35], last_frame[36:55], CMD_EN);
        end
    endtask

    task automatic test_codec_not_ready();
        bit [6:0]  a = 7'($urandom);
        bit [15:0] d = 16'($urandom);
        int syncs = 0;
        int rdy_bad = 0;
        bit [19:0] want_s1, want_s2;
        wait_cnt(8'd100);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr = a;
        cmd_data = d;
        codec_ready = 1'b0;
        @(negedge BIT_CLK);
        cmd_valid = 1'b0;
        wait_cnt(8'd255);
        for (int k = 0; k < 256; k++) begin
            @(negedge BIT_CLK);
            syncs += int'(SYNC);
            if (cmd_ready !== 1'b0) rdy_bad++;
            if (m_cnt == 8'd128) codec_ready = 1'b1;
        end
        @(negedge BIT_CLK);
        n_cmp++;
        if (last_frame !== 256'b0) begin
            n_fail++;
            $display("FAIL nr_frame_zero: got %h want 0", last_frame);
        end
        n_cmp++;
        if (syncs != 16 || rdy_bad != 0) begin
            n_fail++;
            $display("FAIL nr_sync_ready: got sync=%0d ready_high=%0d want 16 0", syncs, rdy_bad);
        end
        want_s1 = CMD_EN ? {1'b0, a, 12'h000} : 20'h0;
        want_s2 = CMD_EN ? {d, 4'h0} : 20'h0;
        wait_cnt(8'd255);
        @(negedge BIT_CLK);
        n_cmp++;
        if (last_frame[0:15] !== (CMD_EN ? 16'hF800 : 16'h9800) ||
            last_frame[16:35] !== want_s1 || last_frame[36:55] !== want_s2) begin
            n_fail++;
            $display("FAIL nr_sent_later: got %h %h %h want tag cmd_en=%b %h %h",
                     last_frame[0:15], last_frame[16:35], last_frame[36:55], CMD_EN,
                     want_s1, want_s2);
        end
    endtask

    task automatic test_reset_midframe();
        wait_cnt(8'd50);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr = 7'($urandom);
        cmd_data = 16'($urandom);
        @(negedge BIT_CLK);
        cmd_valid = 1'b0;
        wait_cnt(8'd60);
        RST_N = 1'b0;
        @(negedge BIT_CLK);
        n_cmp++;
        if ({SYNC, SDATA_OUT, frame_sig, cmd_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset_pins: got %b want 0000",
                     {SYNC, SDATA_OUT, frame_sig, cmd_ready});
        end
        repeat (2) @(negedge BIT_CLK);
        RST_N = 1'b1;
        @(negedge BIT_CLK);
        n_cmp++;
        if ({SYNC, frame_sig, cmd_ready} !== {2'b10, CMD_EN}) begin
            n_fail++;
            $display("FAIL mid_reset_restart: got %b want %b", {SYNC, frame_sig, cmd_ready},
                     {2'b10, CMD_EN});
        end
        wait_cnt(8'd255);
        @(negedge BIT_CLK);
        n_cmp++;
        if (last_frame[0:15] !== 16'h9800 || last_frame[16:35] !== 20'h0) begin
            n_fail++;
            $display("FAIL mid_reset_cleared: got tag %h s1 %h want 9800 00000",
                     last_frame[0:15], last_frame[16:35]);
        end
    endtask

    task automatic test_random();
        codec_ready = 1'b1;
        for (int k = 0; k < 8 * 256; k++) begin
            @(negedge BIT_CLK);
            n_cmp++;
            if ({SYNC, SDATA_OUT, frame_sig, cmd_ready} !== exp_out()) begin
                n_fail++;
                $display("FAIL rand_pins cnt=%0d: got %b want %b", m_cnt,
                         {SYNC, SDATA_OUT, frame_sig, cmd_ready}, exp_out());
            end
            if ($urandom_range(0, 7) == 0) PCM_LR = 18'($urandom);
            if (m_cnt == 8'd128) codec_ready = ($urandom_range(0, 3) != 0);
            cmd_valid = ($urandom_range(0, 39) == 0);
            cmd_write = 1'($urandom);
            cmd_addr = 7'($urandom);
            cmd_data = 16'($urandom);
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pcm_stream();
        test_capture_hold();
        test_write_cmd();
        test_read_boundary();
        test_codec_not_ready();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ac97_frame_tx.md
# ac97_frame_tx

Serializes one AC'97 output frame (256 bit periods) per 48 kHz sample period: drives SYNC and SDATA_OUT to the codec and carries the mixed PCM_LR sample plus optional codec-register commands. It sits between the mix controller and the codec pins. It also generates the frame_sig pulse that the wave generators and the mix controller use to advance one sample.

## Interface
- SAMPLE_W, 18: width of PCM_LR; left-justified into 20-bit slots, must be ≤ 20
- BIT_CLK  in  1  AC'97 bit clock from codec, 12.288 MHz; single clock domain
- RST_N  in  1  reset, synchronous, active-low
- PCM_LR  in  SAMPLE_W  mixed sample, unsigned; sent identically on left (slot 3) and right (slot 4)
- codec_ready  in  1  codec-ready flag, already synchronized to BIT_CLK
- cmd_valid  in  1  command request
- cmd_ready  out  1  command buffer empty
- cmd_write  in  1  1 = register write, 0 = register read
- cmd_addr  in  7  codec register address
- cmd_data  in  16  write data; ignored for reads
- SYNC  out  1  frame sync to codec
- SDATA_OUT  out  1  serial data to codec, MSB-first
- frame_sig  out  1  one-cycle pulse at the last bit period of each frame

## Operation
- Bit counter cnt runs 0..255 and wraps 255→0. The frame boundary is the edge where cnt goes 255→0.
- Frame layout, bit index = cnt:
  - slot 0 (tag), bits 0..15:
    - bit 15 = frame valid
    - bit 14 = slot 1 valid
    - bit 13 = slot 2 valid
    - bit 12 = slot 3 valid
    - bit 11 = slot 4 valid
    - all other tag bits 0
  - slot 1, bits 16..35 (20 bits): read/write flag (1 = read), 7-bit address, then 12 zeros.
  - slot 2, bits 36..55: 16 data bits, then 4 zeros.
  - slot 3, bits 56..75 and slot 4, bits 76..95: {PCM_LR, (20−SAMPLE_W) zeros}.
  - bits 96..255: 0.
- At each frame boundary, shadow registers load:
  - PCM_LR;
  - codec_ready;
  - the command buffer contents, if the buffer is full.
- The frame then transmits only from the shadow registers; input changes mid-frame have no effect.
- Tag values:
  - codec_ready = 1: bits 15, 12 and 11 set.
  - Command loaded: bit 14 set; bit 13 set only for a write.
  - codec_ready = 0: entire frame is zero, and the buffered command is NOT consumed (it stays in the buffer).
- Command handshake:
  - One-entry buffer; cmd_ready = buffer empty.
  - A transfer occurs on an edge with cmd_valid && cmd_ready; the buffer becomes full.
  - The buffer empties only at a frame boundary where it loads into the shadow registers.
  - Boundary decisions use the buffer state before the edge. A command accepted on the boundary edge itself is sent in the following frame.
  - Slot 1 of a read carries data slot 2 = 0 with tag bit 13 clear.
- Reset:
  - cnt = 255, all shadow registers 0, buffer empty.
  - SYNC = 0, SDATA_OUT = 0, frame_sig = 0; cmd_ready = 0 during reset.
  - Reset asserted mid-frame aborts the frame immediately, with no partial completion.

## Timing
- SYNC, SDATA_OUT and frame_sig are registers, computed from the next cnt value. In the cycle where cnt = k they present bit k; the codec samples them on the falling edge.
- SYNC = 1 for cnt 0..15.
- frame_sig = 1 in the cycle where cnt = 255, once every 256 cycles. It is not asserted while RST_N is low.
- First edge after RST_N rises: cnt = 0 and SYNC = 1; the first frame starts.
- PCM_LR present on the edge ending the frame_sig cycle appears in the next frame: slot 3 MSB at cnt 56.
- Latency from sample capture to slot 3 MSB on the pin: 56 cycles.
- A command accepted mid-frame is sent in the next frame. Worst-case latency: 256 + 16 cycles to slot 1 MSB.
- cmd_ready returns high on the cycle after the boundary that consumed the command.

## Configuration
- AC97_TX_CMD_EN:
  - Defined: command buffer, slot 1/2 serialization and tag bits 14/13 as above.
  - Undefined: cmd_ready tied 0; cmd_* inputs ignored; slots 1 and 2 and tag bits 14/13 are always 0. Audio behaviour is identical to the defined case.

## Structure
- Package ac97_pkg:
  - FRAME_BITS = 256, TAG_BITS = 16, SLOT_BITS = 20;
  - slot start offsets SLOT1_START = 16, SLOT2_START = 36, SLOT3_START = 56, SLOT4_START = 76;
  - tag bit index constants.
- One sub-module, ac97_cmd_buffer: the one-entry valid/ready holding register with its consume strobe. It is compiled only under AC97_TX_CMD_EN.
- Top level holds the counter, the shadow registers and the slot/bit multiplexer.

## Test plan
- PCM stream:
  - Stimulus: release reset; codec_ready = 1; PCM_LR = 18'h2AAAA held.
  - Expected: SYNC high for exactly cnt 0..15 every 256 cycles; tag = 16'h9800; slots 3 and 4 = 20'hAAAA8; frame_sig pulses every 256 cycles at cnt 255.
- Sample capture and hold:
  - Stimulus: change PCM_LR 18'h00001→18'h3FFFF at cnt 100.
  - Expected: current frame is unaffected; next frame slot 3 = 20'hFFFFC.
- Write command:
  - Stimulus: write to addr 7'h02, data 16'h0808, accepted at cnt 40.
  - Expected: cmd_ready low until the next boundary; next frame tag = 16'hF800; slot 1 = 20'h02000; slot 2 = 20'h08080; the frame after has tag 16'h9800.
- Read accepted on boundary:
  - Stimulus: read addr 7'h26, accepted on the 255→0 edge.
  - Expected: not in the frame just started; the following frame has tag 16'hD800 and slot 1 = 20'hA6000.
- codec_ready low:
  - Stimulus: codec_ready = 0 with a buffered write.
  - Expected: SDATA_OUT all 0 and SYNC still toggles; command stays buffered with cmd_ready = 0; after codec_ready = 1 it is sent in the next frame.
- Reset mid-frame:
  - Stimulus: assert RST_N low at cnt 60 for 3 cycles.
  - Expected: SYNC/SDATA_OUT/frame_sig are 0 on the following edge; the buffer is cleared; a clean frame starts at cnt 0 on the first edge after release.
